// File: rtl/pipeline_defs.sv
// Shared MIPS pipeline encodings used by the MEM/WB stage and the register file.
package pipeline_defs;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    REGDST_RT = 2'd0,
    REGDST_RD = 2'd1,
    REGDST_RA = 2'd2,
    REGDST_K0 = 2'd3
  } regdst_e;

  typedef enum logic [1:0] {
    MTR_ALU = 2'd0,
    MTR_MEM = 2'd1,
    MTR_PC4 = 2'd2
  } memtoreg_e;

  localparam logic [REG_AW-1:0] REG_RA   = 5'd31;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: async-reset storage, one write port,
// two write-through read ports and an unbypassed debug port.
module regfile_2r1w
  import pipeline_defs::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [XLEN-1:0]   rs_data,
  output logic [XLEN-1:0]   rt_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  logic [XLEN-1:0] regs [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  // Bypass lets ID see the value being retired this cycle.
  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == REG_ZERO)                rs_data = '0;
    else if (we && (rs_addr == waddr))      rs_data = wdata;
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == REG_ZERO)                rt_data = '0;
    else if (we && (rt_addr == waddr))      rt_data = wdata;
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: destination/data decode, register file and
// retired-instruction counter.
module wb_regfile
  import pipeline_defs::*;
#(
  parameter int NREG = 32,
  parameter int XLEN = 32,
  parameter int KREG = 26
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       IR_wb_in,
  input  logic [XLEN-1:0]   PC_plus_4_wb_in,
  input  logic [XLEN-1:0]   Memory_Read_Data_wb_in,
  input  logic [XLEN-1:0]   ALU_out_wb_in,
  input  logic              RegWrite_wb_in,
  input  logic [1:0]        RegDst_wb_in,
  input  logic [1:0]        MemtoReg_wb_in,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  output logic [XLEN-1:0]   rs_data,
  output logic [XLEN-1:0]   rt_data,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_addr,
  output logic [XLEN-1:0]   wb_data,
  output logic [31:0]       retire_count,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [XLEN-1:0]   dbg_data
);

  always_comb begin
    wb_addr = IR_wb_in[20:16];
    case (RegDst_wb_in)
      REGDST_RT: wb_addr = IR_wb_in[20:16];
      REGDST_RD: wb_addr = IR_wb_in[15:11];
      REGDST_RA: wb_addr = REG_RA;
      REGDST_K0: wb_addr = REG_AW'(KREG);
      default:   wb_addr = IR_wb_in[20:16];
    endcase
  end

  // Encoding 3 is unassigned and falls back to the ALU result.
  always_comb begin
    wb_data = ALU_out_wb_in;
    case (MemtoReg_wb_in)
      MTR_MEM: wb_data = Memory_Read_Data_wb_in;
      MTR_PC4: wb_data = PC_plus_4_wb_in;
      default: wb_data = ALU_out_wb_in;
    endcase
  end

  assign wb_we = RegWrite_wb_in && (wb_addr != REG_ZERO);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                retire_count <= '0;
    else if (IR_wb_in != '0)  retire_count <= retire_count + 32'd1;
  end

  regfile_2r1w #(
    .NREG(NREG),
    .XLEN(XLEN)
  ) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we       (wb_we),
    .waddr    (wb_addr),
    .wdata    (wb_data),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface; it is the write-back stage plus the architectural register file of the 5-stage MIPS pipeline.
- Takes the registered MEM/WB fields, selects the destination register and the write data, and writes the 32x32 register file on the clock edge.
- Serves the two ID-stage read ports with same-cycle write-through bypass.
- Exports the write-back tuple to the forwarding unit and keeps a retired-instruction counter.

Parameters:
- NREG, 32, number of architectural registers (address width log2(NREG) = 5).
- XLEN, 32, datapath width.
- KREG, 26, destination index used when RegDst = 3 (exception link, $k0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IR_wb_in  in  32  instruction word from MEM/WB.
- PC_plus_4_wb_in  in  32  PC+4 from MEM/WB.
- Memory_Read_Data_wb_in  in  32  load data from MEM/WB.
- ALU_out_wb_in  in  32  ALU result from MEM/WB.
- RegWrite_wb_in  in  1  write enable from MEM/WB.
- RegDst_wb_in  in  2  destination select.
- MemtoReg_wb_in  in  2  data select.
- rs_addr  in  5  ID read port 1 address.
- rt_addr  in  5  ID read port 2 address.
- rs_data  out  32  read port 1 data.
- rt_data  out  32  read port 2 data.
- wb_we  out  1  effective write enable, to the forwarding unit.
- wb_addr  out  5  effective destination register.
- wb_data  out  32  effective write data.
- retire_count  out  32  count of retired non-NOP instructions.
- dbg_addr  in  5  debug read address.
- dbg_data  out  32  debug read data (combinational, no bypass).

Behaviour:
- Destination decode (combinational):
  - RegDst 0 -> IR[20:16]
  - RegDst 1 -> IR[15:11]
  - RegDst 2 -> 31
  - RegDst 3 -> KREG
- Data decode (combinational):
  - MemtoReg 0 -> ALU_out
  - MemtoReg 1 -> Memory_Read_Data
  - MemtoReg 2 -> PC_plus_4
  - MemtoReg 3 -> ALU_out
- wb_we = RegWrite_wb_in AND (wb_addr != 0). wb_addr and wb_data are always driven with the decoded values, even when wb_we = 0.
- Register write: on the rising clk edge with wb_we = 1, regs[wb_addr] <= wb_data. Register 0 is never written and always reads 0.
- Read ports (combinational):
  - Address 0 -> 0.
  - Else, if wb_we and address == wb_addr -> wb_data (write-through bypass).
  - Else -> regs[address].
  - Both ports bypass independently; rs_addr == rt_addr returns the same value on both.
- Retire counter: increments by 1 on each rising edge where IR_wb_in != 0, independent of RegWrite (stores and branches count; bubbles do not). Wraps from 0xFFFFFFFF to 0 silently.
- Reset (asynchronous, immediate):
  - All 32 registers become 0 and retire_count becomes 0.
  - Combinational outputs follow the inputs.
  - Reset asserted coincident with a clock edge: reset wins, no write occurs.
  - First write happens on the first rising edge after deassertion.
- Latency: a write-back value is visible on rs_data/rt_data in the same cycle through the bypass, and in the array from the next cycle on.

Decomposition:
- Shared package (pipeline_defs) holds:
  - RegDst encodings: REGDST_RT = 0, REGDST_RD = 1, REGDST_RA = 2, REGDST_K0 = 3.
  - MemtoReg encodings: MTR_ALU = 0, MTR_MEM = 1, MTR_PC4 = 2.
  - REG_RA = 31, REG_ZERO = 0.
- One natural sub-module, regfile_2r1w: the storage array, async reset, two bypassed read ports and the debug port.
- wb_regfile instantiates regfile_2r1w and contains the destination and data decode plus the retire counter.

Test Plan:
- Reset, then read all 32 addresses via dbg_addr -> every value 0; retire_count = 0.
- Write: IR = 0x012A4020 (add $8,$9,$10), RegDst = 1, MemtoReg = 0, ALU_out = 0x0000BEEF, RegWrite = 1, with rs_addr = 8 in the same cycle -> rs_data = 0x0000BEEF via bypass; next cycle dbg reg 8 = 0x0000BEEF; retire_count = 1.
- Load to $0: IR = 0x8C000004 (lw $0), RegDst = 0, MemtoReg = 1, RegWrite = 1, data 0x12345678 -> wb_we = 0; reg 0 still reads 0 on both ports.
- jal: RegDst = 2, MemtoReg = 2, PC_plus_4 = 0x00400010 -> reg 31 = 0x00400010; wb_addr = 31.
- Bubble: IR = 0 with RegWrite = 0 for 3 cycles -> retire_count unchanged. Then a store (IR = 0xAD280000, RegWrite = 0) -> retire_count +1 and no register changes.
- Reset mid-stream: assert reset between edges after regs 8 and 31 are written -> both read 0 immediately. Reset held across an edge with RegWrite = 1 -> no write occurs.
